div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage, directly downstream of the main decoder.
- Launched by DIV/DIVU: a decode with HLwrite=1 and funct DIV or DIVU drives start_i.
- Produces a 64-bit {remainder, quotient} result for the HI/LO write path.
- Holds stall_o while busy so the pipeline freezes IF/ID/EX.

Parameters:
- DATA_W, 32, operand width. Quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- start_i  input  1  launch request; sampled only in IDLE
- signed_i  input  1  1=DIV (two's complement), 0=DIVU; sampled with start_i
- annul_i  input  1  pipeline flush or exception; abandons the operation in flight
- opdata1_i  input  DATA_W  dividend (rs)
- opdata2_i  input  DATA_W  divisor (rt)
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; goes to HI/LO
- ready_o  output  1  one-cycle pulse; result_o valid and HI/LO write enabled
- stall_o  output  1  pipeline hold request

Behaviour:
- Reset (resetn=0, async): state=IDLE, counter=0, result_o=0, ready_o=0, stall_o=0. Reset mid-operation aborts immediately; no ready_o pulse follows.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On start_i=1 and annul_i=0, capture operands and go to BUSY.
  - Captured values: |dividend|, |divisor|, sign of quotient (signed_i & (a[31]^b[31])), sign of remainder (signed_i & a[31]).
  - Unsigned mode uses operands unmodified.
- BUSY:
  - One quotient bit per cycle, MSB first.
  - Partial remainder is DATA_W+1 bits: shift left, trial subtract divisor; if the result is non-negative, keep it and set the quotient bit to 1.
  - Counter counts 0..DATA_W-1. At DATA_W-1, go to DONE.
- DONE:
  - Apply sign correction (two's-complement negate quotient and/or remainder), register into result_o.
  - ready_o=1 for exactly this cycle, then IDLE.
- Latency: start accepted in cycle T, ready_o high in cycle T+DATA_W+1 (33 for default).
- stall_o (combinational) = (state==IDLE & start_i & ~annul_i) | state==BUSY.
  - stall_o is low in DONE, so the pipeline advances the same cycle HI/LO are written.
- result_o holds its last value outside DONE. Only ready_o qualifies it.
- annul_i:
  - In BUSY or DONE, go to IDLE next cycle. No ready_o; result_o is not updated.
  - In IDLE with start_i, the start is ignored.
- Divide by zero: same latency, no trap.
  - Quotient = all ones (natural restoring output).
  - Remainder = dividend.
  - Sign correction still applies in signed mode.
- Overflow, signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wrap-around, no exception).
- start_i during BUSY or DONE is ignored. The pipeline is stalled, so this only occurs under annul.
- Back-to-back divides: a new start is accepted in the IDLE cycle immediately after DONE.

Decomposition:
- Shared defines header: FSM state encodings (DIV_IDLE, DIV_BUSY, DIV_DONE), DIV/DIVU funct codes, DATA_W.
- One natural sub-module: div_neg, a combinational conditional two's-complement negate. It is instantiated for operand abs-value and for result sign correction.

Test Plan:
- Unsigned: DIVU 100 / 7, start at T -> ready_o at T+33, result_o={0x00000002, 0x0000000E}; stall_o high T..T+32, low at T+33.
- Signed mixed signs: DIV -7 (0xFFFFFFF9) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Zero and overflow: DIVU 0x12345678 / 0 -> {0x12345678, 0xFFFFFFFF} at T+33; DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Annul: start DIVU 50 / 5, assert annul_i at T+10 -> IDLE at T+11, stall_o low from T+11, no ready_o through T+40, result_o unchanged. Then a fresh DIVU 9 / 3 completes with {0, 3}.
- Reset mid-operation: drop resetn at T+20 -> state, ready_o, stall_o and result_o zero immediately (asynchronous), no ready_o after release.
- Back-to-back: DIVU 0xFFFFFFFF / 0x10 then DIV 15 / -4 started in the first IDLE cycle after ready_o -> {0x0000000F, 0x0FFFFFFF} then {0x00000003, 0xFFFFFFFD}, exactly 34 cycles apart.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle EX-stage divider: FSM states,
// the DIV/DIVU funct codes that launch it, and the default operand width.
package div_unit_pkg;

   localparam int DIV_DATA_W = 32;

   localparam logic [5:0] FUNCT_DIV  = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU = 6'b011011;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // Decoder-side helper: a HI/LO-writing op with one of these functs drives start_i.
   function automatic logic is_div_funct(input logic [5:0] funct);
      return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Pipeline <-> divider handshake: launch/flush controls and operands in,
// {remainder, quotient} result with its ready pulse and the stall request out.
interface div_unit_if #(parameter int DATA_W = 32);

   logic                  start_i;
   logic                  signed_i;
   logic                  annul_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;
   logic                  stall_o;

   modport master (
      output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
      input  result_o, ready_o, stall_o
   );

   modport slave (
      input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
      output result_o, ready_o, stall_o
   );

endinterface

// File: rtl/div_unit_neg.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the signs of quotient and remainder.
module div_neg #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] din,
   input  logic              neg,
   output logic [DATA_W-1:0] dout
);

   assign dout = neg ? DATA_W'(-din) : din;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// sign correction in DONE, stalls the pipeline while the iteration runs.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W,
   parameter int CNT_W  = 6
) (
   input logic       clk,
   input logic       resetn,
   div_unit_if.slave dif
);

   div_state_t            state;
   logic [CNT_W-1:0]      cnt;
   logic [2*DATA_W-1:0]   result_q;

   logic [DATA_W-1:0]     rem;
   logic [DATA_W-1:0]     quo;
   logic [DATA_W-1:0]     dvs;
   logic                  neg_q;
   logic                  neg_r;

   logic [DATA_W-1:0]     abs_a;
   logic [DATA_W-1:0]     abs_b;
   logic [DATA_W-1:0]     quo_fix;
   logic [DATA_W-1:0]     rem_fix;
   logic [DATA_W:0]       shifted;
   logic [DATA_W:0]       trial;
   logic                  accept;
   logic                  last_iter;

   assign accept    = (state == DIV_IDLE) && dif.start_i && !dif.annul_i;
   assign last_iter = (cnt == CNT_W'(DATA_W - 1));

   div_neg #(.DATA_W(DATA_W)) u_abs_a (
      .din  (dif.opdata1_i),
      .neg  (dif.signed_i & dif.opdata1_i[DATA_W-1]),
      .dout (abs_a)
   );

   div_neg #(.DATA_W(DATA_W)) u_abs_b (
      .din  (dif.opdata2_i),
      .neg  (dif.signed_i & dif.opdata2_i[DATA_W-1]),
      .dout (abs_b)
   );

   div_neg #(.DATA_W(DATA_W)) u_fix_q (
      .din  (quo),
      .neg  (neg_q),
      .dout (quo_fix)
   );

   div_neg #(.DATA_W(DATA_W)) u_fix_r (
      .din  (rem),
      .neg  (neg_r),
      .dout (rem_fix)
   );

   // The dividend is shifted out of quo's MSB as quotient bits shift in.
   // rem < divisor keeps trial below 2^DATA_W when non-negative, so its MSB is the borrow.
   assign shifted = {rem, quo[DATA_W-1]};
   assign trial   = shifted - {1'b0, dvs};

   // ---- control: FSM, iteration counter, held result ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= DIV_IDLE;
         cnt      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (accept) begin
                  state <= DIV_BUSY;
                  cnt   <= '0;
               end
            end
            DIV_BUSY: begin
               if (dif.annul_i) begin
                  state <= DIV_IDLE;
               end else if (last_iter) begin
                  state <= DIV_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DIV_DONE: begin
               state <= DIV_IDLE;
               if (!dif.annul_i) begin
                  result_q <= {rem_fix, quo_fix};
               end
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

   // ---- datapath: operand capture and restoring iteration ----
   always_ff @(posedge clk) begin
      if (accept) begin
         rem   <= '0;
         quo   <= abs_a;
         dvs   <= abs_b;
         neg_q <= dif.signed_i & (dif.opdata1_i[DATA_W-1] ^ dif.opdata2_i[DATA_W-1]);
         neg_r <= dif.signed_i & dif.opdata1_i[DATA_W-1];
      end else if (state == DIV_BUSY) begin
         rem <= trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
         quo <= {quo[DATA_W-2:0], ~trial[DATA_W]};
      end
   end

   // Result is visible in the DONE cycle itself and held afterwards.
   assign dif.ready_o  = (state == DIV_DONE) && !dif.annul_i;
   assign dif.result_o = dif.ready_o ? {rem_fix, quo_fix} : result_q;
   assign dif.stall_o  = accept || (state == DIV_BUSY);

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed DIV/DIVU vectors with literal results, plus a
// per-cycle comparison of ready/stall/result against an arithmetic model.
module tb_div_unit;

   localparam int DW  = 32;
   localparam int LAT = DW + 1;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   div_unit_if #(.DATA_W(DW)) dif ();

   div_unit #(.DATA_W(DW), .CNT_W(6)) dut (
      .clk    (clk),
      .resetn (resetn),
      .dif    (dif)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [31:0] ua, ub, q, r;
      ua = (s && a[31]) ? -a : a;
      ub = (s && b[31]) ? -b : b;
      if (ub == 0) begin
         q = 32'hFFFF_FFFF;
         r = ua;
      end else begin
         q = ua / ub;
         r = ua % ub;
      end
      if (s && (a[31] ^ b[31])) q = -q;
      if (s && a[31]) r = -r;
      return {r, q};
   endfunction

   // Scoreboard: at most one divide in flight, ready expected LAT cycles after acceptance.
   bit          pend = 0;
   int          t_start = 0;
   logic [63:0] exp_res = '0;
   logic [63:0] last_res = '0;

   always @(negedge clk) begin
      logic        e_rdy, e_stall;
      logic [63:0] e_res;
      if (!resetn) begin
         pend     = 0;
         last_res = '0;
         chk("rst_result", dif.result_o, 64'd0);
         chk("rst_ready", dif.ready_o, 0);
         chk("rst_stall", dif.stall_o, 0);
      end else begin
         if (pend && cyc == t_start + LAT) begin
            e_rdy   = !dif.annul_i;
            e_stall = 1'b0;
            e_res   = dif.annul_i ? last_res : exp_res;
         end else if (pend) begin
            e_rdy   = 1'b0;
            e_stall = 1'b1;
            e_res   = last_res;
         end else begin
            e_rdy   = 1'b0;
            e_stall = dif.start_i && !dif.annul_i;
            e_res   = last_res;
         end
         chk("cyc_ready", dif.ready_o, e_rdy);
         chk("cyc_stall", dif.stall_o, e_stall);
         chk("cyc_result", dif.result_o, e_res);
         if (pend) begin
            if (dif.annul_i) begin
               pend = 0;
            end else if (cyc == t_start + LAT) begin
               last_res = exp_res;
               pend     = 0;
            end
         end else if (dif.start_i && !dif.annul_i) begin
            pend    = 1;
            t_start = cyc;
            exp_res = model(dif.opdata1_i, dif.opdata2_i, dif.signed_i);
         end
      end
   end

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] want, input string name, output int rdy_cyc);
      int t0;
      bit got;
      @(posedge clk); #1;
      dif.start_i   = 1'b1;
      dif.signed_i  = s;
      dif.opdata1_i = a;
      dif.opdata2_i = b;
      t0 = cyc;
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      got = 0;
      rdy_cyc = -1;
      for (int i = 0; i < LAT + 5 && !got; i++) begin
         @(negedge clk);
         if (cyc == t0 + LAT - 1) chk({name, "_stall_last_busy"}, dif.stall_o, 1);
         if (dif.ready_o) begin
            got = 1;
            rdy_cyc = cyc;
            chk({name, "_result"}, dif.result_o, want);
            chk({name, "_latency"}, cyc - t0, LAT);
            chk({name, "_stall_done"}, dif.stall_o, 0);
         end
      end
      chk({name, "_ready_seen"}, got, 1);
   endtask

   initial begin
      int r1, r2, t0, pulses;
      dif.start_i   = 1'b0;
      dif.signed_i  = 1'b0;
      dif.annul_i   = 1'b0;
      dif.opdata1_i = '0;
      dif.opdata2_i = '0;

      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (2) @(posedge clk);

      run_div(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, "divu_100_7", r1);
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2", r1);
      run_div(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, "divu_by_zero", r1);
      run_div(32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'h0000_0001}, "div_m7_by_zero", r1);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, "div_overflow", r1);

      // Annul in the middle of BUSY: no ready, held result untouched.
      @(posedge clk); #1;
      dif.start_i   = 1'b1;
      dif.signed_i  = 1'b0;
      dif.opdata1_i = 32'd50;
      dif.opdata2_i = 32'd5;
      t0 = cyc;
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1 dif.annul_i = 1'b1;
      @(posedge clk); #1;
      dif.annul_i = 1'b0;
      @(negedge clk);
      chk("annul_stall_low", dif.stall_o, 0);
      pulses = 0;
      while (cyc < t0 + 40) begin
         @(negedge clk);
         if (dif.ready_o) pulses++;
      end
      chk("annul_no_ready", pulses, 0);
      chk("annul_result_held", dif.result_o, {32'h0000_0000, 32'h8000_0000});

      // Start together with annul in IDLE is ignored.
      @(posedge clk); #1;
      dif.start_i = 1'b1;
      dif.annul_i = 1'b1;
      @(negedge clk);
      chk("start_annul_stall", dif.stall_o, 0);
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      dif.annul_i = 1'b0;
      repeat (3) @(posedge clk);

      run_div(32'd9, 32'd3, 1'b0, {32'h0000_0000, 32'h0000_0003}, "divu_9_3", r1);

      // Back-to-back: second start in the first IDLE cycle after ready.
      run_div(32'hFFFF_FFFF, 32'h10, 1'b0, {32'h0000_000F, 32'h0FFF_FFFF}, "b2b_first", r1);
      run_div(32'd15, 32'hFFFF_FFFC, 1'b1, {32'h0000_0003, 32'hFFFF_FFFD}, "b2b_second", r2);
      chk("b2b_spacing", r2 - r1, 34);

      // Asynchronous reset mid-operation.
      @(posedge clk); #1;
      dif.start_i   = 1'b1;
      dif.signed_i  = 1'b0;
      dif.opdata1_i = 32'd100;
      dif.opdata2_i = 32'd7;
      t0 = cyc;
      @(posedge clk); #1;
      dif.start_i = 1'b0;
      repeat (19) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_result", dif.result_o, 64'd0);
      chk("async_rst_ready", dif.ready_o, 0);
      chk("async_rst_stall", dif.stall_o, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (dif.ready_o) pulses++;
      end
      chk("rst_no_ready_after", pulses, 0);
      chk("rst_result_stays_zero", dif.result_o, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
